// File: rtl/sample_walker_if.sv
// Triangle-in / sample-out signal bundle for the sample walker.
// The slave modport is the walker; the master modport is the driver and observer.
interface sample_walker_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                          validTri_R13H;
  logic        [3:0]                             subSample_RnnnnU;
  logic                                          stall_R14H;
  logic                                          busy_R13H;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic signed [1:0][SIGFIG-1:0]                 sample_R14S;
  logic                                          validSamp_R14H;

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, stall_R14H,
    output busy_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, stall_R14H,
    input  busy_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_walker.sv
// Walks a triangle's bounding box in raster order at the selected sample rate.
// Emits one sample per unstalled cycle while in TEST.
//   state | meaning
//   WAIT  | idle, accepting a new triangle
//   TEST  | emitting samples of the latched box
module sample_walker #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input logic           clk,
  input logic           rst,
  sample_walker_if.slave bus
);
  typedef enum logic {WAIT, TEST} state_t;

  state_t                                        state;
  logic                                          busy;
  logic                                          valid;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_q;
  logic signed [SIGFIG-1:0]                      ll_x, ll_y, ur_x, ur_y;
  logic signed [SIGFIG-1:0]                      samp_x, samp_y;
  logic signed [SIGFIG-1:0]                      step, step_sel;
  logic signed [SIGFIG:0]                        next_x, next_y, ur_x_ext, ur_y_ext;
  logic                                          x_fits, y_fits;

  always_comb begin
    step_sel = SIGFIG'(1) << RADIX;
    case (bus.subSample_RnnnnU)
      4'b1000: step_sel = SIGFIG'(1) << RADIX;
      4'b0100: step_sel = SIGFIG'(1) << (RADIX - 1);
      4'b0010: step_sel = SIGFIG'(1) << (RADIX - 2);
      4'b0001: step_sel = SIGFIG'(1) << (RADIX - 3);
      default: step_sel = SIGFIG'(1) << RADIX;
    endcase
  end

  // One extra bit keeps x+step from wrapping past the upper-right bound.
  always_comb begin
    next_x   = $signed({samp_x[SIGFIG-1], samp_x}) + $signed({step[SIGFIG-1], step});
    next_y   = $signed({samp_y[SIGFIG-1], samp_y}) + $signed({step[SIGFIG-1], step});
    ur_x_ext = $signed({ur_x[SIGFIG-1], ur_x});
    ur_y_ext = $signed({ur_y[SIGFIG-1], ur_y});
    x_fits   = next_x <= ur_x_ext;
    y_fits   = next_y <= ur_y_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT;
      busy    <= 1'b0;
      valid   <= 1'b0;
      tri_q   <= '0;
      color_q <= '0;
      ll_x    <= '0;
      ll_y    <= '0;
      ur_x    <= '0;
      ur_y    <= '0;
      step    <= '0;
      samp_x  <= '0;
      samp_y  <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (bus.validTri_R13H) begin
            tri_q   <= bus.tri_R13S;
            color_q <= bus.color_R13U;
            ll_x    <= bus.box_R13S[0][0];
            ll_y    <= bus.box_R13S[0][1];
            ur_x    <= bus.box_R13S[1][0];
            ur_y    <= bus.box_R13S[1][1];
            step    <= step_sel;
            samp_x  <= bus.box_R13S[0][0];
            samp_y  <= bus.box_R13S[0][1];
            busy    <= 1'b1;
            valid   <= 1'b1;
            state   <= TEST;
          end
        end
        TEST: begin
          if (!bus.stall_R14H) begin
            if (x_fits) begin
              samp_x <= next_x[SIGFIG-1:0];
            end else if (y_fits) begin
              samp_x <= ll_x;
              samp_y <= next_y[SIGFIG-1:0];
            end else begin
              busy  <= 1'b0;
              valid <= 1'b0;
              state <= WAIT;
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  assign bus.busy_R13H      = busy;
  assign bus.validSamp_R14H = valid;
  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
  assign bus.sample_R14S[0] = samp_x;
  assign bus.sample_R14S[1] = samp_y;
endmodule

// File: tb/tb_sample_walker.sv
// Directed bench for sample_walker: raster order, sample rates, stall, back-to-back, reset.
module tb_sample_walker;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   mon_lo_x, mon_hi_x, mon_lo_y, mon_hi_y;

  sample_walker_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

  sample_walker #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [47:0] xy(input int x, input int y);
    return {24'(y), 24'(x)};
  endfunction

  function automatic logic [VERTS*AXIS*SIGFIG-1:0] mk_tri(input int base);
    logic [VERTS*AXIS*SIGFIG-1:0] t;
    for (int i = 0; i < VERTS * AXIS; i++) t[i*SIGFIG +: SIGFIG] = 24'(base + i);
    return t;
  endfunction

  function automatic logic [COLORS*SIGFIG-1:0] mk_col(input int base);
    logic [COLORS*SIGFIG-1:0] c;
    for (int i = 0; i < COLORS; i++) c[i*SIGFIG +: SIGFIG] = 24'(base + 3 * i);
    return c;
  endfunction

  task automatic set_box(input int llx, input int lly, input int urx, input int ury);
    bus.box_R13S[0][0] = 24'(llx);
    bus.box_R13S[0][1] = 24'(lly);
    bus.box_R13S[1][0] = 24'(urx);
    bus.box_R13S[1][1] = 24'(ury);
  endtask

  task automatic set_mon(input int llx, input int lly, input int urx, input int ury);
    mon_lo_x = (llx < urx) ? llx : urx;
    mon_hi_x = (llx < urx) ? urx : llx;
    mon_lo_y = (lly < ury) ? lly : ury;
    mon_hi_y = (lly < ury) ? ury : lly;
  endtask

  task automatic exp_samp(input string tag, input int x, input int y);
    chk({tag, ".valid"}, 256'(bus.validSamp_R14H), 256'(1));
    chk({tag, ".xy"}, 256'(bus.sample_R14S), 256'(xy(x, y)));
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".valid"}, 256'(bus.validSamp_R14H), 256'(0));
    chk({tag, ".busy"}, 256'(bus.busy_R13H), 256'(0));
  endtask

  // Continuous invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("valid_eq_busy", 256'(bus.validSamp_R14H), 256'(bus.busy_R13H));
      if (bus.validSamp_R14H === 1'b1) begin
        checks++;
        assert ($signed(bus.sample_R14S[0]) >= mon_lo_x && $signed(bus.sample_R14S[0]) <= mon_hi_x &&
                $signed(bus.sample_R14S[1]) >= mon_lo_y && $signed(bus.sample_R14S[1]) <= mon_hi_y)
          passes++;
        else $error("FAIL in_box observed=%0h expected within x[%0d,%0d] y[%0d,%0d]",
                    bus.sample_R14S, mon_lo_x, mon_hi_x, mon_lo_y, mon_hi_y);
      end
    end
  end

  initial begin
    int ex [6];
    int ey [6];
    ex = '{0, 1024, 2048, 0, 1024, 2048};
    ey = '{0, 0, 0, 1024, 1024, 1024};
    set_mon(0, 0, 0, 0);
    rst = 1'b1;
    bus.tri_R13S = '0;
    bus.color_R13U = '0;
    bus.box_R13S = '0;
    bus.validTri_R13H = 1'b0;
    bus.subSample_RnnnnU = 4'b1000;
    bus.stall_R14H = 1'b0;
    tick();
    tick();
    chk("rst.busy", 256'(bus.busy_R13H), 256'(0));
    chk("rst.valid", 256'(bus.validSamp_R14H), 256'(0));
    chk("rst.sample", 256'(bus.sample_R14S), 256'(0));
    chk("rst.tri", 256'(bus.tri_R14S), 256'(0));
    chk("rst.color", 256'(bus.color_R14U), 256'(0));
    rst = 1'b0;
    tick();
    exp_idle("idle");

    // 1x raster, tri/color must not follow input changes during TEST
    bus.tri_R13S = mk_tri(100);
    bus.color_R13U = mk_col(7);
    set_box(0, 0, 2048, 1024);
    bus.validTri_R13H = 1'b1;
    tick();
    set_mon(0, 0, 2048, 1024);
    bus.validTri_R13H = 1'b0;
    bus.tri_R13S = mk_tri(900);
    bus.color_R13U = mk_col(55);
    bus.subSample_RnnnnU = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      exp_samp($sformatf("x1.s%0d", i), ex[i], ey[i]);
      chk($sformatf("x1.tri%0d", i), 256'(bus.tri_R14S), 256'(mk_tri(100)));
      chk($sformatf("x1.col%0d", i), 256'(bus.color_R14U), 256'(mk_col(7)));
    end
    tick();
    exp_idle("x1.end");

    // 4x degenerate box
    bus.subSample_RnnnnU = 4'b0100;
    set_box(512, 512, 512, 512);
    bus.validTri_R13H = 1'b1;
    tick();
    set_mon(512, 512, 512, 512);
    bus.validTri_R13H = 1'b0;
    exp_samp("x4.s0", 512, 512);
    tick();
    exp_idle("x4.end");

    // Stall at first sample for 3 cycles
    bus.subSample_RnnnnU = 4'b1000;
    set_box(0, 0, 1024, 0);
    bus.validTri_R13H = 1'b1;
    bus.stall_R14H = 1'b1;
    tick();
    set_mon(0, 0, 1024, 0);
    bus.validTri_R13H = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      exp_samp($sformatf("stall.hold%0d", i), 0, 0);
    end
    bus.stall_R14H = 1'b0;
    tick();
    exp_samp("stall.s1", 1024, 0);
    tick();
    exp_idle("stall.end");

    // Back-to-back with validTri held high
    bus.tri_R13S = mk_tri(300);
    set_box(0, 0, 1024, 0);
    bus.validTri_R13H = 1'b1;
    tick();
    set_mon(0, 0, 1024, 0);
    exp_samp("b2b.a0", 0, 0);
    bus.tri_R13S = mk_tri(500);
    set_box(2048, 0, 2048, 0);
    tick();
    exp_samp("b2b.a1", 1024, 0);
    chk("b2b.tri_a", 256'(bus.tri_R14S), 256'(mk_tri(300)));
    tick();
    exp_idle("b2b.bubble");
    tick();
    set_mon(2048, 0, 2048, 0);
    bus.validTri_R13H = 1'b0;
    exp_samp("b2b.b0", 2048, 0);
    chk("b2b.tri_b", 256'(bus.tri_R14S), 256'(mk_tri(500)));
    tick();
    exp_idle("b2b.end");

    // Reset at the third sample of the 6-sample box; reset beats stall and validTri
    set_box(0, 0, 2048, 1024);
    bus.validTri_R13H = 1'b1;
    tick();
    set_mon(0, 0, 2048, 1024);
    bus.validTri_R13H = 1'b0;
    tick();
    tick();
    exp_samp("rst.s2", 2048, 0);
    rst = 1'b1;
    bus.stall_R14H = 1'b1;
    bus.validTri_R13H = 1'b1;
    tick();
    exp_idle("rstmid");
    chk("rstmid.sample", 256'(bus.sample_R14S), 256'(0));
    chk("rstmid.tri", 256'(bus.tri_R14S), 256'(0));
    chk("rstmid.color", 256'(bus.color_R14U), 256'(0));
    rst = 1'b0;
    bus.stall_R14H = 1'b0;
    bus.validTri_R13H = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_idle($sformatf("rstmid.after%0d", i));
    end

    // 64x step of 128
    bus.subSample_RnnnnU = 4'b0001;
    set_box(0, 0, 256, 0);
    bus.validTri_R13H = 1'b1;
    tick();
    set_mon(0, 0, 256, 0);
    bus.validTri_R13H = 1'b0;
    exp_samp("x64.s0", 0, 0);
    tick();
    exp_samp("x64.s1", 128, 0);
    tick();
    exp_samp("x64.s2", 256, 0);
    tick();
    exp_idle("x64.end");

    // Inverted box: single sample at lower-left
    bus.subSample_RnnnnU = 4'b1000;
    set_box(1024, 1024, 0, 0);
    bus.validTri_R13H = 1'b1;
    tick();
    set_mon(1024, 1024, 0, 0);
    bus.validTri_R13H = 1'b0;
    exp_samp("inv.s0", 1024, 1024);
    tick();
    exp_idle("inv.end");

    // Negative coordinates
    set_box(-2048, -1024, -1024, -1024);
    bus.validTri_R13H = 1'b1;
    tick();
    set_mon(-2048, -1024, -1024, -1024);
    bus.validTri_R13H = 1'b0;
    exp_samp("neg.s0", -2048, -1024);
    tick();
    exp_samp("neg.s1", -1024, -1024);
    tick();
    exp_idle("neg.end");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
